// File: rtl/dep_issue_if.sv
// Pair-issue bus between decode and dep_issue.
// master = decode side / testbench, slave = dep_issue.
interface dep_issue_if #(
  parameter int unsigned LAT_W = 3
);
  // Decode -> issue
  logic             flush;
  logic             in_valid;
  logic             odd_older_ip;
  logic [10:0]      opcode_even_ip;
  logic [10:0]      opcode_odd_ip;
  logic [2:0]       unitType_even_ip;
  logic [2:0]       unitType_odd_ip;
  logic [6:0]       regRA_addr_even_ip;
  logic [6:0]       regRA_addr_odd_ip;
  logic [6:0]       regRB_addr_even_ip;
  logic [6:0]       regRB_addr_odd_ip;
  logic [6:0]       regRC_addr_even_ip;
  logic [6:0]       regRC_addr_odd_ip;
  logic [6:0]       regRT_addr_even_ip;
  logic [6:0]       regRT_addr_odd_ip;
  logic [15:0]      imm_even_ip;
  logic [15:0]      imm_odd_ip;
  logic             wr_even_ip;
  logic             wr_odd_ip;
  logic             rc_is_rt_even_ip;
  logic             rc_is_rt_odd_ip;
  logic [LAT_W-1:0] lat_even_ip;
  logic [LAT_W-1:0] lat_odd_ip;
  logic [31:0]      PC_ip;

  // Issue -> decode / execute
  logic             in_ready;
  logic [10:0]      opcode_even;
  logic [10:0]      opcode_odd;
  logic [2:0]       unitType_even;
  logic [2:0]       unitType_odd;
  logic [6:0]       regRA_addr_even;
  logic [6:0]       regRA_addr_odd;
  logic [6:0]       regRB_addr_even;
  logic [6:0]       regRB_addr_odd;
  logic [6:0]       regRC_addr_even;
  logic [6:0]       regRC_addr_odd;
  logic [6:0]       regRT_addr_even;
  logic [6:0]       regRT_addr_odd;
  logic [15:0]      imm_even;
  logic [15:0]      imm_odd;
  logic [31:0]      PC_odd_dep;
  logic             priority_dep;
  logic [31:0]      stall_cnt;

  modport master (
    output flush, in_valid, odd_older_ip,
    output opcode_even_ip, opcode_odd_ip, unitType_even_ip, unitType_odd_ip,
    output regRA_addr_even_ip, regRA_addr_odd_ip, regRB_addr_even_ip, regRB_addr_odd_ip,
    output regRC_addr_even_ip, regRC_addr_odd_ip, regRT_addr_even_ip, regRT_addr_odd_ip,
    output imm_even_ip, imm_odd_ip, wr_even_ip, wr_odd_ip,
    output rc_is_rt_even_ip, rc_is_rt_odd_ip, lat_even_ip, lat_odd_ip, PC_ip,
    input  in_ready,
    input  opcode_even, opcode_odd, unitType_even, unitType_odd,
    input  regRA_addr_even, regRA_addr_odd, regRB_addr_even, regRB_addr_odd,
    input  regRC_addr_even, regRC_addr_odd, regRT_addr_even, regRT_addr_odd,
    input  imm_even, imm_odd, PC_odd_dep, priority_dep, stall_cnt
  );

  modport slave (
    input  flush, in_valid, odd_older_ip,
    input  opcode_even_ip, opcode_odd_ip, unitType_even_ip, unitType_odd_ip,
    input  regRA_addr_even_ip, regRA_addr_odd_ip, regRB_addr_even_ip, regRB_addr_odd_ip,
    input  regRC_addr_even_ip, regRC_addr_odd_ip, regRT_addr_even_ip, regRT_addr_odd_ip,
    input  imm_even_ip, imm_odd_ip, wr_even_ip, wr_odd_ip,
    input  rc_is_rt_even_ip, rc_is_rt_odd_ip, lat_even_ip, lat_odd_ip, PC_ip,
    output in_ready,
    output opcode_even, opcode_odd, unitType_even, unitType_odd,
    output regRA_addr_even, regRA_addr_odd, regRB_addr_even, regRB_addr_odd,
    output regRC_addr_even, regRC_addr_odd, regRT_addr_even, regRT_addr_odd,
    output imm_even, imm_odd, PC_odd_dep, priority_dep, stall_cnt
  );
endinterface

// File: rtl/dep_issue.sv
// Dual-slot dependency check and issue stage.
// A per-register countdown scoreboard tracks results in flight. A decoded pair issues
// together when independent, otherwise the older slot goes first and the younger waits
// in SPLIT until its sources are free.
// Optional feature: define STALL_CNT_EN to count cycles a valid pair is held back.
module dep_issue #(
  parameter int unsigned LAT_W = 3,
  parameter int unsigned NREG  = 128
) (
  input logic         clk,
  input logic         rst_n,
  dep_issue_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [LAT_W-1:0] r_cnt     [NREG];
  logic [LAT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_busy;

  logic [6:0] w_third_even, w_third_odd;
  logic       w_free_even, w_free_odd;
  logic       w_old_free, w_yng_free;
  logic       w_conflict;
  logic       w_iss_even, w_iss_odd;
  logic       w_in_ready;

  // Busy flags straight off the scoreboard
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  // Per-slot source hazard check; the third source is RT for read-modify-write ops
  always_comb begin
    w_third_even = bus.rc_is_rt_even_ip ? bus.regRT_addr_even_ip : bus.regRC_addr_even_ip;
    w_third_odd  = bus.rc_is_rt_odd_ip  ? bus.regRT_addr_odd_ip  : bus.regRC_addr_odd_ip;
    w_free_even  = !w_busy[bus.regRA_addr_even_ip] && !w_busy[bus.regRB_addr_even_ip] &&
                   !w_busy[w_third_even];
    w_free_odd   = !w_busy[bus.regRA_addr_odd_ip] && !w_busy[bus.regRB_addr_odd_ip] &&
                   !w_busy[w_third_odd];
    w_old_free   = bus.odd_older_ip ? w_free_odd  : w_free_even;
    w_yng_free   = bus.odd_older_ip ? w_free_even : w_free_odd;
  end

  // Older slot's destination feeds or overwrites something the younger slot touches
  always_comb begin
    if (bus.odd_older_ip) begin
      w_conflict = bus.wr_odd_ip &&
                   ((bus.regRT_addr_odd_ip == bus.regRA_addr_even_ip) ||
                    (bus.regRT_addr_odd_ip == bus.regRB_addr_even_ip) ||
                    (bus.regRT_addr_odd_ip == w_third_even) ||
                    (bus.regRT_addr_odd_ip == bus.regRT_addr_even_ip));
    end else begin
      w_conflict = bus.wr_even_ip &&
                   ((bus.regRT_addr_even_ip == bus.regRA_addr_odd_ip) ||
                    (bus.regRT_addr_even_ip == bus.regRB_addr_odd_ip) ||
                    (bus.regRT_addr_even_ip == w_third_odd) ||
                    (bus.regRT_addr_even_ip == bus.regRT_addr_odd_ip));
    end
  end

  // Issue decision and RUN/SPLIT next state
  always_comb begin
    w_iss_even  = 1'b0;
    w_iss_odd   = 1'b0;
    w_in_ready  = 1'b0;
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_RUN;
    end else if (bus.in_valid) begin
      if (r_state == ST_RUN) begin
        if (w_old_free && w_yng_free && !w_conflict) begin
          w_iss_even = 1'b1;
          w_iss_odd  = 1'b1;
          w_in_ready = 1'b1;
        end else if (w_old_free) begin
          w_iss_even  = !bus.odd_older_ip;
          w_iss_odd   = bus.odd_older_ip;
          w_state_nxt = ST_SPLIT;
        end
      end else begin
        // Older slot already went; only the younger one is left
        if (w_yng_free) begin
          w_iss_even  = bus.odd_older_ip;
          w_iss_odd   = !bus.odd_older_ip;
          w_in_ready  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
    end
  end

  assign bus.in_ready = w_in_ready;

  // Scoreboard next state: saturating decrement, new writers keep the longer wait
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = (r_cnt[i] == '0) ? '0 : (r_cnt[i] - LAT_W'(1));
      if (w_iss_even && bus.wr_even_ip && (bus.regRT_addr_even_ip == 7'(i)) &&
          (bus.lat_even_ip > w_cnt_nxt[i])) begin
        w_cnt_nxt[i] = bus.lat_even_ip;
      end
      if (w_iss_odd && bus.wr_odd_ip && (bus.regRT_addr_odd_ip == 7'(i)) &&
          (bus.lat_odd_ip > w_cnt_nxt[i])) begin
        w_cnt_nxt[i] = bus.lat_odd_ip;
      end
      if (bus.flush) begin
        w_cnt_nxt[i] = '0;
      end
    end
  end

  // Scoreboard and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Even-slot output register; a non-issued slot becomes an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.opcode_even     <= '0;
      bus.unitType_even   <= '0;
      bus.regRA_addr_even <= '0;
      bus.regRB_addr_even <= '0;
      bus.regRC_addr_even <= '0;
      bus.regRT_addr_even <= '0;
      bus.imm_even        <= '0;
    end else begin
      bus.opcode_even     <= w_iss_even ? bus.opcode_even_ip     : '0;
      bus.unitType_even   <= w_iss_even ? bus.unitType_even_ip   : '0;
      bus.regRA_addr_even <= w_iss_even ? bus.regRA_addr_even_ip : '0;
      bus.regRB_addr_even <= w_iss_even ? bus.regRB_addr_even_ip : '0;
      bus.regRC_addr_even <= w_iss_even ? bus.regRC_addr_even_ip : '0;
      bus.regRT_addr_even <= w_iss_even ? bus.regRT_addr_even_ip : '0;
      bus.imm_even        <= w_iss_even ? bus.imm_even_ip        : '0;
    end
  end

  // Odd-slot output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.opcode_odd     <= '0;
      bus.unitType_odd   <= '0;
      bus.regRA_addr_odd <= '0;
      bus.regRB_addr_odd <= '0;
      bus.regRC_addr_odd <= '0;
      bus.regRT_addr_odd <= '0;
      bus.imm_odd        <= '0;
    end else begin
      bus.opcode_odd     <= w_iss_odd ? bus.opcode_odd_ip     : '0;
      bus.unitType_odd   <= w_iss_odd ? bus.unitType_odd_ip   : '0;
      bus.regRA_addr_odd <= w_iss_odd ? bus.regRA_addr_odd_ip : '0;
      bus.regRB_addr_odd <= w_iss_odd ? bus.regRB_addr_odd_ip : '0;
      bus.regRC_addr_odd <= w_iss_odd ? bus.regRC_addr_odd_ip : '0;
      bus.regRT_addr_odd <= w_iss_odd ? bus.regRT_addr_odd_ip : '0;
      bus.imm_odd        <= w_iss_odd ? bus.imm_odd_ip        : '0;
    end
  end

  // Pair PC and slot order, captured whenever either slot issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.PC_odd_dep   <= '0;
      bus.priority_dep <= 1'b0;
    end else if (w_iss_even || w_iss_odd) begin
      bus.PC_odd_dep   <= bus.PC_ip;
      bus.priority_dep <= bus.odd_older_ip;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Held-back cycles, saturating; flush deliberately leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (bus.in_valid && !w_in_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dep_issue.sv
// Directed table-driven bench for dep_issue plus hand-written flush/reset/stall sequences.
module tb_dep_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic       exp_prio = 1'b0;
  logic [31:0] exp_pc = '0;

  dep_issue_if #(.LAT_W(3)) bus ();

  dep_issue #(.LAT_W(3), .NREG(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] op;
    logic [2:0]  ut;
    logic [6:0]  ra, rb, rc, rt;
    logic [15:0] imm;
    logic        wr, rcrt;
    logic [2:0]  lat;
  } slot_t;

  typedef struct {
    logic        valid, oo;
    logic [31:0] pc;
    slot_t       ev, od;
    logic        exp_rdy, exp_e, exp_o;
  } vec_t;

  vec_t vecs[$];

  function automatic slot_t mk(input int op, input int ra, input int rb, input int rc,
                               input int rt, input int wr, input int rcrt, input int lat);
    slot_t s;
    s.op   = 11'(op);
    s.ut   = 3'(op);
    s.ra   = 7'(ra);
    s.rb   = 7'(rb);
    s.rc   = 7'(rc);
    s.rt   = 7'(rt);
    s.imm  = 16'((op * 257) ^ 16'hA5A5);
    s.wr   = (wr != 0);
    s.rcrt = (rcrt != 0);
    s.lat  = 3'(lat);
    return s;
  endfunction

  function automatic vec_t mkv(input int valid, input int oo, input int pc, input slot_t ev,
                               input slot_t od, input int r, input int e, input int o);
    vec_t v;
    v.valid = (valid != 0);
    v.oo = (oo != 0);
    v.pc = 32'(pc);
    v.ev = ev;
    v.od = od;
    v.exp_rdy = (r != 0);
    v.exp_e = (e != 0);
    v.exp_o = (o != 0);
    return v;
  endfunction

  function automatic logic [57:0] pack(input slot_t s);
    return {s.op, s.ut, s.ra, s.rb, s.rc, s.rt, s.imm};
  endfunction

  function automatic logic [57:0] act_even();
    return {bus.opcode_even, bus.unitType_even, bus.regRA_addr_even, bus.regRB_addr_even,
            bus.regRC_addr_even, bus.regRT_addr_even, bus.imm_even};
  endfunction

  function automatic logic [57:0] act_odd();
    return {bus.opcode_odd, bus.unitType_odd, bus.regRA_addr_odd, bus.regRB_addr_odd,
            bus.regRC_addr_odd, bus.regRT_addr_odd, bus.imm_odd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid           = v.valid;
    bus.odd_older_ip       = v.oo;
    bus.PC_ip              = v.pc;
    bus.opcode_even_ip     = v.ev.op;
    bus.unitType_even_ip   = v.ev.ut;
    bus.regRA_addr_even_ip = v.ev.ra;
    bus.regRB_addr_even_ip = v.ev.rb;
    bus.regRC_addr_even_ip = v.ev.rc;
    bus.regRT_addr_even_ip = v.ev.rt;
    bus.imm_even_ip        = v.ev.imm;
    bus.wr_even_ip         = v.ev.wr;
    bus.rc_is_rt_even_ip   = v.ev.rcrt;
    bus.lat_even_ip        = v.ev.lat;
    bus.opcode_odd_ip      = v.od.op;
    bus.unitType_odd_ip    = v.od.ut;
    bus.regRA_addr_odd_ip  = v.od.ra;
    bus.regRB_addr_odd_ip  = v.od.rb;
    bus.regRC_addr_odd_ip  = v.od.rc;
    bus.regRT_addr_odd_ip  = v.od.rt;
    bus.imm_odd_ip         = v.od.imm;
    bus.wr_odd_ip          = v.od.wr;
    bus.rc_is_rt_odd_ip    = v.od.rcrt;
    bus.lat_odd_ip         = v.od.lat;
  endtask

  // One cycle: drive, check the combinational ready, clock, check the registered result
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " even"}, 64'(act_even()), v.exp_e ? 64'(pack(v.ev)) : 64'(0));
    chk({tag, " odd"}, 64'(act_odd()), v.exp_o ? 64'(pack(v.od)) : 64'(0));
    if (v.exp_e || v.exp_o) begin
      exp_prio = v.oo;
      exp_pc   = v.pc;
    end
    chk({tag, " priority_dep"}, 64'(bus.priority_dep), 64'(exp_prio));
    chk({tag, " PC_odd_dep"}, 64'(bus.PC_odd_dep), 64'(exp_pc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " even"}, 64'(act_even()), 64'(0));
    chk({tag, " odd"}, 64'(act_odd()), 64'(0));
    chk({tag, " priority_dep"}, 64'(bus.priority_dep), 64'(0));
    chk({tag, " PC_odd_dep"}, 64'(bus.PC_odd_dep), 64'(0));
    chk({tag, " stall_cnt"}, 64'(bus.stall_cnt), 64'(0));
  endtask

  // Scoreboard contents noted per row as cN = count of register N seen that cycle
  task automatic build_table();
    slot_t a, b;
    // Independent pair: c5 <- 2, c6 <- 4
    a = mk(11'h011, 1, 2, 1, 5, 1, 0, 2); b = mk(11'h012, 1, 2, 1, 6, 1, 0, 4);
    vecs.push_back(mkv(1, 0, 32'h100, a, b, 1, 1, 1));
    // Readers of r5 / r6 probe the loaded counts
    a = mk(11'h013, 5, 2, 1, 8, 0, 0, 0); b = mk(11'h014, 6, 2, 1, 9, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h110, a, b, 0, 0, 0));   // c5=2 c6=4
    vecs.push_back(mkv(1, 0, 32'h110, a, b, 0, 0, 0));   // c5=1 c6=3
    vecs.push_back(mkv(1, 0, 32'h110, a, b, 0, 1, 0));   // c5=0 c6=2: older alone
    vecs.push_back(mkv(1, 0, 32'h110, a, b, 0, 0, 0));   // SPLIT c6=1
    vecs.push_back(mkv(1, 0, 32'h110, a, b, 1, 0, 1));   // SPLIT c6=0
    // Odd older writes r3 (lat 3), even reads RB=r3
    a = mk(11'h022, 1, 3, 1, 11, 0, 0, 0); b = mk(11'h021, 1, 2, 1, 3, 1, 0, 3);
    vecs.push_back(mkv(1, 1, 32'h200, a, b, 0, 0, 1));
    vecs.push_back(mkv(1, 1, 32'h200, a, b, 0, 0, 0));   // c3=3
    vecs.push_back(mkv(1, 1, 32'h200, a, b, 0, 0, 0));   // c3=2
    vecs.push_back(mkv(1, 1, 32'h200, a, b, 0, 0, 0));   // c3=1
    vecs.push_back(mkv(1, 1, 32'h200, a, b, 1, 1, 0));   // c3=0
    // Third source is RT: r20 busy, RC=r1 free
    a = mk(11'h031, 1, 2, 1, 20, 1, 0, 2); b = mk(11'h032, 1, 2, 1, 21, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h300, a, b, 1, 1, 1));
    a = mk(11'h033, 1, 2, 1, 20, 0, 1, 0); b = mk(11'h034, 1, 2, 1, 22, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h310, a, b, 0, 0, 0));   // c20=2, younger free but blocked
    vecs.push_back(mkv(1, 0, 32'h310, a, b, 0, 0, 0));   // c20=1
    vecs.push_back(mkv(1, 0, 32'h310, a, b, 1, 1, 1));
    // r0 is an ordinary register
    a = mk(11'h041, 1, 2, 1, 0, 1, 0, 1); b = mk(11'h042, 1, 2, 1, 23, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h400, a, b, 1, 1, 1));
    a = mk(11'h043, 0, 2, 1, 24, 0, 0, 0); b = mk(11'h044, 1, 2, 1, 27, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h410, a, b, 0, 0, 0));   // c0=1
    vecs.push_back(mkv(1, 0, 32'h410, a, b, 1, 1, 1));
    // No valid pair: bubbles, nothing captured
    vecs.push_back(mkv(0, 0, 32'h4FF, a, b, 0, 0, 0));
    // Same destination in both slots forces a split
    a = mk(11'h051, 1, 2, 1, 25, 1, 0, 1); b = mk(11'h052, 1, 2, 1, 25, 1, 0, 2);
    vecs.push_back(mkv(1, 0, 32'h500, a, b, 0, 1, 0));
    vecs.push_back(mkv(1, 0, 32'h500, a, b, 1, 0, 1));
    // Shorter re-write keeps the longer remaining wait: c26 = max(1, 5-1) = 4
    a = mk(11'h061, 1, 2, 1, 26, 1, 0, 5); b = mk(11'h062, 1, 2, 1, 28, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h600, a, b, 1, 1, 1));
    a = mk(11'h063, 1, 2, 1, 26, 1, 0, 1); b = mk(11'h064, 1, 2, 1, 28, 0, 0, 0);
    vecs.push_back(mkv(1, 0, 32'h610, a, b, 1, 1, 1));
    // Older odd reads r26, younger even free: both held
    a = mk(11'h066, 1, 2, 1, 28, 0, 0, 0); b = mk(11'h065, 26, 2, 1, 29, 0, 0, 0);
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(1, 1, 32'h620, a, b, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 32'h620, a, b, 1, 1, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t  v;
    slot_t a, b;
    int    stalls;
    logic [63:0] exp_stall;

    bus.flush = 1'b0;
    a = mk(0, 0, 0, 0, 0, 0, 0, 0);
    drive(mkv(0, 0, 0, a, a, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset in_ready", 64'(bus.in_ready), 64'(0));

    // First pair lands on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    build_table();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Reset while the younger slot waits in SPLIT
    a = mk(11'h081, 1, 2, 1, 30, 1, 0, 7); b = mk(11'h082, 30, 2, 1, 33, 0, 0, 0);
    v = mkv(1, 0, 32'h800, a, b, 0, 1, 0);
    apply(v, "pre_rst");
    drive(v);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_prio = 1'b0;
    exp_pc   = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a = mk(11'h091, 30, 2, 1, 34, 0, 0, 0); b = mk(11'h092, 30, 2, 1, 35, 0, 0, 0);
    apply(mkv(1, 0, 32'h900, a, b, 1, 1, 1), "post_rst");

    // r10 written with lat 6; dependent pair arrives one idle cycle later
    a = mk(11'h0A1, 1, 2, 1, 10, 1, 0, 6); b = mk(11'h0A2, 1, 2, 1, 36, 0, 0, 0);
    apply(mkv(1, 0, 32'hA00, a, b, 1, 1, 1), "lat6_prod");
    apply(mkv(0, 0, 32'hA00, a, b, 0, 0, 0), "lat6_idle");
    a = mk(11'h0A3, 10, 2, 1, 37, 0, 0, 0); b = mk(11'h0A4, 1, 2, 1, 38, 0, 0, 0);
    v = mkv(1, 0, 32'hA10, a, b, 1, 1, 1);
    drive(v);
    stalls = 0;
    #1;
    while (!bus.in_ready && stalls < 20) begin
      stalls++;
      @(posedge clk);
      #1;
      chk("lat6 bubble even", 64'(act_even()), 64'(0));
    end
    chk("lat6 stall_cycles", 64'(stalls), 64'(5));
    apply(v, "lat6_cons");
`ifdef STALL_CNT_EN
    exp_stall = 64'(5);
`else
    exp_stall = 64'(0);
`endif
    chk("stall_cnt", 64'(bus.stall_cnt), exp_stall);

    // Flush in SPLIT with c7=4 clears the scoreboard and returns to RUN
    a = mk(11'h0B1, 1, 2, 1, 7, 1, 0, 4); b = mk(11'h0B2, 7, 2, 1, 39, 0, 0, 0);
    v = mkv(1, 0, 32'hB00, a, b, 0, 1, 0);
    apply(v, "pre_flush");
    drive(v);
    bus.flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("flush even", 64'(act_even()), 64'(0));
    chk("flush odd", 64'(act_odd()), 64'(0));
    chk("flush PC_odd_dep", 64'(bus.PC_odd_dep), 64'(exp_pc));
    bus.flush = 1'b0;
    a = mk(11'h0B3, 7, 2, 1, 40, 0, 0, 0); b = mk(11'h0B4, 1, 7, 1, 41, 0, 0, 0);
    apply(mkv(1, 0, 32'hB10, a, b, 1, 1, 1), "post_flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
